// File: rtl/fdown_engine.sv
// Game-state engine for the falling-floors game: scrolling floors with random gaps,
// a steerable ball, score/high score, ramping speed and an IDLE/RUN/PAUSE/OVER FSM.
module fdown_engine #(
    parameter int          N_FLOORS      = 3,
    parameter int          W             = 10,
    parameter int          SCORE_W       = 20,
    parameter int          H_ACTIVE      = 640,
    parameter int          V_ACTIVE      = 480,
    parameter int          BALL_R        = 8,
    parameter int          BALL_SPEED    = 2,
    parameter int          FLOOR_SPACING = 200,
    parameter int          GAP_MIN       = 40,
    parameter int          SPEED_INIT    = 1,
    parameter int          SPEED_MAX     = 6,
    parameter int          SPEED_STEP    = 600,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  start_pulse,
    input  logic [1:0]            dir,
    output logic [W-1:0]          ball_x,
    output logic [W-1:0]          ball_y,
    output logic [N_FLOORS*W-1:0] floor_y,
    output logic [N_FLOORS*W-1:0] gap_x,
    output logic [N_FLOORS*W-1:0] gap_w,
    output logic [W-1:0]          speed,
    output logic [SCORE_W-1:0]    score,
    output logic [SCORE_W-1:0]    high_score,
    output logic [1:0]            state
);

    localparam int XW    = W + 1;
    localparam int CNT_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP + 1) : 1;

    localparam logic [XW-1:0] C_R     = XW'(BALL_R);
    localparam logic [XW-1:0] C_STEP  = XW'(BALL_SPEED);
    localparam logic [XW-1:0] C_H     = XW'(H_ACTIVE);
    localparam logic [XW-1:0] C_V     = XW'(V_ACTIVE);
    localparam logic [XW-1:0] C_THICK = XW'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_lfsr;
    logic [W-1:0]       r_bx, r_by, r_speed;
    logic [W-1:0]       r_fy [N_FLOORS];
    logic [W-1:0]       r_gx [N_FLOORS];
    logic [W-1:0]       r_gw [N_FLOORS];
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score, r_hs;

    logic               w_do_frame, w_reinit, w_over, w_recycle;
    logic               w_left_ok, w_right_ok, w_hit;
    logic [W-1:0]       w_hit_y, w_bx_nxt, w_by_nxt, w_speed_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SCORE_W-1:0] w_score_inc;
    logic [XW-1:0]      w_new_gx, w_new_gw;
    logic [W-1:0]       w_fy_nxt [N_FLOORS];
    logic [W-1:0]       w_gx_nxt [N_FLOORS];
    logic [W-1:0]       w_gw_nxt [N_FLOORS];

    function automatic logic [XW-1:0] ext(input logic [W-1:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [W-1:0] sub_clamp(input logic [XW-1:0] a, input logic [XW-1:0] b);
        logic [XW-1:0] d;
        d = a - b;
        return (a > b) ? d[W-1:0] : '0;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    assign w_over = ext(r_by) < ext(r_speed);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A start press in the same cycle as a frame tick takes the transition and drops the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_do_frame  = 1'b0;
        w_reinit    = 1'b0;
        case (r_state)
            S_IDLE:  if (start_pulse) w_state_nxt = S_RUN;
            S_RUN: begin
                if (start_pulse) begin
                    w_state_nxt = S_PAUSE;
                end else if (frame_tick) begin
                    w_do_frame = 1'b1;
                    if (w_over) w_state_nxt = S_OVER;
                end
            end
            S_PAUSE: if (start_pulse) w_state_nxt = S_RUN;
            S_OVER: begin
                if (start_pulse) begin
                    w_state_nxt = S_IDLE;
                    w_reinit    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_score_inc = sat_inc(r_score);
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_speed_nxt = r_speed;
        if (w_cnt_nxt == CNT_W'(SPEED_STEP)) begin
            w_cnt_nxt = '0;
            if (ext(r_speed) < XW'(SPEED_MAX)) w_speed_nxt = r_speed + W'(1);
        end
    end

    // Floor scroll, or recycle the uppermost floor into a fresh random one at the bottom.
    always_comb begin
        w_recycle = ext(r_fy[0]) <= ext(r_speed);
        w_new_gw  = XW'(GAP_MIN) + XW'(r_lfsr[5:0]);
        w_new_gx  = XW'(r_lfsr[15:6]);
        if (w_new_gx + w_new_gw > C_H) w_new_gx = C_H - w_new_gw;
        for (int i = 0; i < N_FLOORS; i++) begin
            w_fy_nxt[i] = sub_clamp(ext(r_fy[i]), ext(r_speed));
            w_gx_nxt[i] = r_gx[i];
            w_gw_nxt[i] = r_gw[i];
        end
        if (w_recycle) begin
            for (int i = 0; i < N_FLOORS - 1; i++) begin
                w_fy_nxt[i] = sub_clamp(ext(r_fy[i+1]), ext(r_speed));
                w_gx_nxt[i] = r_gx[i+1];
                w_gw_nxt[i] = r_gw[i+1];
            end
            w_fy_nxt[N_FLOORS-1] = sub_clamp(ext(r_fy[N_FLOORS-1]) + XW'(FLOOR_SPACING), ext(r_speed));
            w_gx_nxt[N_FLOORS-1] = w_new_gx[W-1:0];
            w_gw_nxt[N_FLOORS-1] = w_new_gw[W-1:0];
        end
    end

    always_comb begin
        w_left_ok  = ext(r_bx) > (C_STEP + C_R);
        w_right_ok = (ext(r_bx) + C_R + C_STEP) < C_H;
        w_hit      = 1'b0;
        w_hit_y    = '0;
        for (int f = 0; f < N_FLOORS; f++) begin
            if ((ext(r_by) + C_R > ext(r_fy[f])) && (ext(r_by) < ext(r_fy[f]) + C_THICK + C_R)) begin
                if (ext(r_bx) < ext(r_gx[f]) + C_R + C_STEP) w_left_ok = 1'b0;
                if (ext(r_bx) + C_R + C_STEP > ext(r_gx[f]) + ext(r_gw[f])) w_right_ok = 1'b0;
            end
            // First (uppermost) floor under the ball that it cannot slip through carries it up.
            if (!w_hit && (ext(r_fy[f]) >= ext(r_by)) &&
                (ext(r_fy[f]) - ext(r_by) < C_R + ext(r_speed)) &&
                ((ext(r_bx) < ext(r_gx[f]) + C_R) || (ext(r_bx) + C_R > ext(r_gx[f]) + ext(r_gw[f])))) begin
                w_hit   = 1'b1;
                w_hit_y = sub_clamp(ext(r_fy[f]), ext(r_speed) + C_R);
            end
        end

        w_bx_nxt = r_bx;
        if (dir == 2'b10 && w_left_ok)       w_bx_nxt = r_bx - W'(BALL_SPEED);
        else if (dir == 2'b01 && w_right_ok) w_bx_nxt = r_bx + W'(BALL_SPEED);

        if (w_over)                        w_by_nxt = '0;
        else if (w_hit)                    w_by_nxt = w_hit_y;
        else if (ext(r_by) + C_R >= C_V)   w_by_nxt = W'(V_ACTIVE - BALL_R);
        else                               w_by_nxt = r_by + W'(BALL_SPEED);
    end

    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    always_ff @(posedge clk) begin
        if (rst)                                                  r_hs <= '0;
        else if (w_do_frame && w_over && (w_score_inc > r_hs))    r_hs <= w_score_inc;
    end

    always_ff @(posedge clk) begin
        if (rst || w_reinit) begin
            r_bx    <= W'(120);
            r_by    <= W'(240);
            r_speed <= W'(SPEED_INIT);
            r_cnt   <= '0;
            r_score <= '0;
            for (int i = 0; i < N_FLOORS; i++) begin
                r_fy[i] <= W'(300 + i * FLOOR_SPACING);
                r_gx[i] <= W'(150 + 50 * i);
                r_gw[i] <= W'(GAP_MIN + 20 * i);
            end
        end else if (w_do_frame) begin
            r_bx    <= w_bx_nxt;
            r_by    <= w_by_nxt;
            r_speed <= w_speed_nxt;
            r_cnt   <= w_cnt_nxt;
            r_score <= w_score_inc;
            for (int i = 0; i < N_FLOORS; i++) begin
                r_fy[i] <= w_fy_nxt[i];
                r_gx[i] <= w_gx_nxt[i];
                r_gw[i] <= w_gw_nxt[i];
            end
        end
    end

    genvar g;
    for (g = 0; g < N_FLOORS; g++) begin : g_flat
        assign floor_y[g*W +: W] = r_fy[g];
        assign gap_x[g*W +: W]   = r_gx[g];
        assign gap_w[g*W +: W]   = r_gw[g];
    end

    assign ball_x     = r_bx;
    assign ball_y     = r_by;
    assign speed      = r_speed;
    assign score      = r_score;
    assign high_score = r_hs;
    assign state      = r_state;

endmodule

// File: doc/fdown_engine.md
Name: fdown_engine

Overview:
- Parametrised game-state engine for the falling-floors game.
- Holds N_FLOORS scrolling floors with random gaps, a ball steered left/right, a score with high score, and difficulty that ramps over time.
- Adds an explicit IDLE/RUN/PAUSE/OVER state machine.
- Sits between the VGA timing block (supplies frame_tick) and the draw/score-display blocks, which consume its flattened position buses.

Parameters:
N_FLOORS, 3, number of simultaneously tracked floors (2..8)
W, 10, coordinate width in bits
SCORE_W, 20, score / high-score width
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in pixels
BALL_R, 8, ball radius
BALL_SPEED, 2, ball pixels per frame, horizontal and falling
FLOOR_SPACING, 200, vertical distance between consecutive floors
GAP_MIN, 40, minimum gap width
SPEED_INIT, 1, initial floor scroll speed (px/frame)
SPEED_MAX, 6, maximum floor scroll speed
SPEED_STEP, 600, frames between speed increments
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-clk pulse per video frame, clk domain
start_pulse  in  1  one-clk debounced start/pause press
dir  in  2  2'b10 left, 2'b01 right, else none
ball_x  out  W  ball centre x
ball_y  out  W  ball centre y
floor_y  out  N_FLOORS*W  floor top y; slot 0 (LSBs) = uppermost floor
gap_x  out  N_FLOORS*W  gap left edge per floor
gap_w  out  N_FLOORS*W  gap width per floor
speed  out  W  current scroll speed
score  out  SCORE_W  current score
high_score  out  SCORE_W  best score since reset
state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 OVER

Behaviour:
- Reset (sync, rst=1 at posedge clk), in place the next cycle:
  - state=IDLE; ball_x=120; ball_y=240; score=0; high_score=0; speed=SPEED_INIT; frame counter=0; LFSR=LFSR_SEED.
  - floor i: floor_y=300+i*FLOOR_SPACING, gap_x=150+50*i, gap_w=GAP_MIN+20*i.
- Reset mid-game wins over every other input.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk in every state (player timing adds entropy); never all-zero.
- FSM (evaluated every clk):
  - IDLE --start_pulse--> RUN.
  - RUN --start_pulse--> PAUSE.
  - RUN --frame_tick with ball_y<speed--> OVER.
  - PAUSE --start_pulse--> RUN.
  - OVER --start_pulse--> IDLE; playfield, score, speed and frame counter re-initialised to reset values; high_score and LFSR kept.
- start_pulse and frame_tick in the same cycle: the transition is taken and that frame's update is skipped.
- Frame update (RUN and frame_tick only; outputs change 1 clk after the tick; everything else holds):
  - score += 1, saturating at all-ones.
  - frame counter += 1; when it reaches SPEED_STEP it clears and speed += 1, capped at SPEED_MAX.
  - Scroll, if floor_y[0] > speed: every floor_y -= speed.
  - Recycle, otherwise:
    - slots shift down (slot i <= slot i+1, minus speed).
    - new top slot: y = old top y + FLOOR_SPACING - speed; gap_w = GAP_MIN + lfsr[5:0]; gap_x = lfsr[15:6] mod-clamped so gap_x+gap_w <= H_ACTIVE (if exceeded, gap_x = H_ACTIVE-gap_w).
  - Floor f blocks the ball vertically when ball_y+BALL_R > floor_y[f] and ball_y < floor_y[f]+4+BALL_R (floor thickness 4).
  - Left move (dir=10): requires ball_x > BALL_SPEED+BALL_R and, for every blocking floor, ball_x >= gap_x+BALL_R+BALL_SPEED; then ball_x -= BALL_SPEED.
  - Right move (dir=01): requires ball_x+BALL_R+BALL_SPEED < H_ACTIVE and, for every blocking floor, ball_x+BALL_R+BALL_SPEED <= gap_x+gap_w; then ball_x += BALL_SPEED.
  - dir=11 or 00: no horizontal move.
  - Vertical, lowest-index floor wins:
    - game-over check first (ball_y<speed: ball_y<=0, state->OVER, high_score<=max(high_score,score+1)).
    - else if floor_y[f] >= ball_y and floor_y[f]-ball_y < BALL_R+speed and the ball is not fully inside the gap (ball_x < gap_x+BALL_R or ball_x+BALL_R > gap_x+gap_w): ball_y = floor_y[f]-speed-BALL_R (carried up).
    - else if ball_y+BALL_R >= V_ACTIVE: ball_y = V_ACTIVE-BALL_R.
    - else ball_y += BALL_SPEED.
- Arithmetic: all comparisons zero-extended to W+1 bits; no wrap on subtraction (guarded by the comparisons above).

Test Plan:
- Reset, then 5 frame_ticks in IDLE -> all outputs hold reset values; state=0; score=0.
- start_pulse, then 10 frames, dir=00, ball over floor 0 solid region -> score=10; floor_y[0]=290; ball lands and tracks floor_y[0]-speed-8.
- RUN with floor_y[0]=1, speed=1, one frame -> slots shift; new top slot y=old top+199; GAP_MIN <= gap_w <= GAP_MIN+63; gap_x+gap_w <= 640.
- Ball resting at y=240 against a floor solid edge, dir=10 -> ball_x unchanged; same with ball inside the gap span -> ball_x decreases by 2 per frame.
- Force ball_y=0 with speed=1, frame_tick -> state=OVER; high_score=score; start_pulse -> IDLE, score=0, high_score retained; a later lower score leaves high_score unchanged.
- SPEED_STEP=4, 30 frames -> speed steps 1,2,...,6 and stays at 6; start_pulse coincident with frame_tick in RUN -> PAUSE, score unchanged.
